// File: rtl/mem_access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_pkg - shared encodings for the load/store memory unit     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_access_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_unit_if - CPU request/response bundle for mem_access_unit |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  modport master (output req, wr, size, uns, addr, wdata,
                  input  ready, done, err, rdata);
  modport slave  (input  req, wr, size, uns, addr, wdata,
                  output ready, done, err, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lane_align - little-endian lane extract/extend and store merge   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_lane_align
  import mem_access_pkg::*;
(
  input  wire logic [31:0] rd_word_i,
  input  wire logic [31:0] wdata_i,
  input  wire logic [1:0]  size_i,
  input  wire logic        uns_i,
  input  wire logic [1:0]  ofs_i,
  output logic      [31:0] load_o,
  output logic      [31:0] merge_o
);

  logic [LANE_W-1:0]   w_byte;
  logic [2*LANE_W-1:0] w_half;

  always_comb begin
    w_byte  = rd_word_i[{ofs_i, 3'b000} +: LANE_W];
    w_half  = ofs_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    load_o  = rd_word_i;
    merge_o = rd_word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{~uns_i & w_byte[7]}}, w_byte};
        merge_o[{ofs_i, 3'b000} +: LANE_W] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{~uns_i & w_half[15]}}, w_half};
        if (ofs_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_unit - sub-word load/store to word RAM with fault checks  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  mem_access_unit_if.slave       cpu,
  output logic                   ram_we_o,
  output logic      [ADDR_W-1:0] ram_adr_o,
  output logic      [31:0]       ram_din_o,
  input  wire logic [31:0]       ram_dout_i
);

  localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic        w_fault;

  mem_lane_align u_align (
    .rd_word_i (ram_dout_i),
    .wdata_i   (wdata_q),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .ofs_i     (addr_q[1:0]),
    .load_o    (w_load),
    .merge_o   (w_merge)
  );

  // Evaluated on the live request so a bad access never leaves IDLE for a RAM state.
  assign w_fault = (cpu.size == SZ_ILL)
                || (cpu.size == SZ_HALF && cpu.addr[0])
                || (cpu.size == SZ_WORD && cpu.addr[1:0] != 2'b00)
                || ({2'b00, cpu.addr[ADDR_W-1:2]} >= c_depth);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu.req) begin
          wr_d    = cpu.wr;
          size_d  = cpu.size;
          uns_d   = cpu.uns;
          addr_d  = cpu.addr;
          wdata_d = cpu.wdata;
          if (w_fault)                 state_d = ST_FAULT;
          else if (!cpu.wr)            state_d = ST_LOAD;
          else if (cpu.size == SZ_WORD) state_d = ST_STORE;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        rdata_d = w_load;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_STORE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RMW_RD: begin
        merge_d = w_merge;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cpu.ready = (state_q == ST_IDLE);
  assign cpu.done  = done_q;
  assign cpu.err   = err_q;
  assign cpu.rdata = rdata_q;

  assign ram_we_o  = wr_q && (state_q == ST_STORE || state_q == ST_RMW_WR);
  assign ram_adr_o = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_din_o = (state_q == ST_RMW_WR) ? merge_q : wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_unit - scoreboard bench with a word RAM model          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_adr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  logic [31:0] mem [0:DEPTH-1];
  int          total_writes = 0;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) ifc ();

  mem_access_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (ifc.slave),
    .ram_we_o   (ram_we),
    .ram_adr_o  (ram_adr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  always #5 clk = ~clk;

  assign ram_dout = (ram_adr[ADDR_W-1:2] < DEPTH) ? mem[ram_adr[8:2]] : 32'h0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_adr[8:2]] <= ram_din;
      total_writes      <= total_writes + 1;
    end
  end

  typedef struct {
    string       name;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          lat;
    int          writes;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   we_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ram_we) we_cnt++;
      if (ifc.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_err"}, {31'd0, ifc.err}, {31'd0, e.err});
          if (e.chk_rd) check({e.name, "_rdata"}, ifc.rdata, e.rdata);
          check({e.name, "_latency"}, cyc - acc_cyc, e.lat);
          check({e.name, "_writes"}, we_cnt, e.writes);
        end
      end
      if (ifc.req && ifc.ready) begin
        acc_cyc = cyc + 1;
        we_cnt  = 0;
      end
    end
  end

  task automatic issue(input string name, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                       input int exp_lat, input int exp_wr);
    exp_t e;
    int   n;
    e.name = name; e.err = exp_err; e.chk_rd = chk_rd; e.rdata = exp_rd;
    e.lat = exp_lat; e.writes = exp_wr;
    sb_q.push_back(e);
    ifc.req = 1'b1; ifc.wr = wr; ifc.size = size; ifc.uns = uns;
    ifc.addr = addr; ifc.wdata = wdata;
    n = 0;
    while (!ifc.ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ifc.ready) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    ifc.req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !ifc.ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[16] = 32'h8899AABB;
    ifc.req = 1'b0; ifc.wr = 1'b0; ifc.size = 2'b00; ifc.uns = 1'b0;
    ifc.addr = '0; ifc.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ram_we", {31'd0, ram_we}, 32'd0);
    check("reset_done", {31'd0, ifc.done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", {31'd0, ifc.ready}, 32'd1);
    check("reset_err", {31'd0, ifc.err}, 32'd0);
    check("reset_rdata", ifc.rdata, 32'h0);

    issue("lb_41",  1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, 1'b0, 1'b1, 32'hFFFFFFAA, 1, 0);
    issue("lbu_41", 1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h0, 1'b0, 1'b1, 32'h000000AA, 1, 0);
    issue("lh_42",  1'b0, SZ_HALF, 1'b0, 32'h42, 32'h0, 1'b0, 1'b1, 32'hFFFF8899, 1, 0);
    issue("lhu_42", 1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 1'b0, 1'b1, 32'h00008899, 1, 0);
    wait_idle();

    issue("sb_42", 1'b1, SZ_BYTE, 1'b0, 32'h42, 32'h11, 1'b0, 1'b0, 32'h0, 2, 1);
    wait_idle();
    check("mem16_after_sb", mem[16], 32'h8811AABB);
    issue("sh_40", 1'b1, SZ_HALF, 1'b0, 32'h40, 32'hCAFE, 1'b0, 1'b0, 32'h0, 2, 1);
    wait_idle();
    check("mem16_after_sh", mem[16], 32'h8811CAFE);

    issue("sw_44", 1'b1, SZ_WORD, 1'b0, 32'h44, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1, 1);
    issue("lw_44", 1'b0, SZ_WORD, 1'b1, 32'h44, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1, 0);
    wait_idle();
    check("mem17_after_sw", mem[17], 32'hDEADBEEF);

    wr_before = total_writes;
    issue("lh_43_misal",  1'b0, SZ_HALF, 1'b0, 32'h43, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1, 0);
    issue("sw_42_misal",  1'b1, SZ_WORD, 1'b0, 32'h42, 32'h12345678, 1'b1, 1'b1, 32'hDEADBEEF, 1, 0);
    issue("size11_at_0",  1'b1, SZ_ILL,  1'b0, 32'h0,  32'hFFFFFFFF, 1'b1, 1'b1, 32'hDEADBEEF, 1, 0);
    issue("sw_200_range", 1'b1, SZ_WORD, 1'b0, 32'h200, 32'hA5A5A5A5, 1'b1, 1'b1, 32'hDEADBEEF, 1, 0);
    wait_idle();
    check("fault_no_writes", total_writes - wr_before, 32'd0);
    check("mem0_unchanged", mem[0], 32'h0);
    check("mem16_unchanged", mem[16], 32'h8811CAFE);

    issue("sw_1fc_last", 1'b1, SZ_WORD, 1'b0, 32'h1FC, 32'h12345678, 1'b0, 1'b0, 32'h0, 1, 1);
    wait_idle();
    check("mem127_written", mem[127], 32'h12345678);

    wr_before = total_writes;
    issue("sb_40_reset", 1'b1, SZ_BYTE, 1'b0, 32'h40, 32'h55, 1'b0, 1'b0, 32'h0, 2, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_ram_we", {31'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    sb_q.delete();
    rst_n = 1'b1;
    check("midreset_ready", {31'd0, ifc.ready}, 32'd1);
    check("midreset_done", {31'd0, ifc.done}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("midreset_no_write", total_writes - wr_before, 32'd0);
    check("midreset_mem16", mem[16], 32'h8811CAFE);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
